quad_decoder: RTL
=================

QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter WIDTH, default 16: width of the position counter pos.
REQ-002 Parameter FILT_LEN, default 3: number of consecutive stable cycles the glitch filter requires, legal range 1..15.
REQ-003 Port clk, input, 1: clock; all logic SHALL be clocked on the rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port enc_a, input, 1: encoder channel A; asynchronous to clk.
REQ-006 Port enc_b, input, 1: encoder channel B; asynchronous to clk.
REQ-007 Port enc_z, input, 1: encoder index pulse; asynchronous to clk.
REQ-008 Port clr, input, 1: synchronous position clear.
REQ-009 Port err_clr, input, 1: synchronous clear of the sticky error flag.
REQ-010 Port step, output, 1: one-cycle pulse per valid quadrature transition.
REQ-011 Port dir, output, 1: direction of the last valid step; 0 = up, 1 = down.
REQ-012 Port zero, output, 1: one-cycle pulse on an accepted index rising edge or on clr.
REQ-013 Port pos, output, WIDTH: signed-agnostic position count.
REQ-014 Port err, output, 1: sticky illegal-transition flag.

Function
REQ-015 Each of enc_a, enc_b and enc_z SHALL pass through a 2-flop synchronizer before any use.
REQ-016 Decoder FSM states:
- INIT: capture the current AB sample as prev_ab; assert no step; move to TRACK next cycle.
- TRACK: compare the current AB sample with prev_ab every cycle.
REQ-017 Up sequence 00->01->11->10->00: step=1, dir=0, pos=pos+1.
REQ-018 Down sequence 00->10->11->01->00: step=1, dir=1, pos=pos-1.
REQ-019 Unchanged AB: step=0; dir and pos hold.
REQ-020 Both A and B change in one cycle: no step, pos holds, err set to 1, prev_ab updated to the new AB.
REQ-021 prev_ab SHALL update to the current AB every TRACK cycle.
REQ-022 pos SHALL wrap modulo 2^WIDTH: all-ones +1 -> 0, and 0 -1 -> all-ones.
REQ-023 Synchronized enc_z rising edge: zero=1 for exactly one cycle and pos=0 at that edge.
REQ-024 clr=1: zero=1 and pos=0 at the next edge; clr held high keeps pos at 0 and zero high.
REQ-025 Index or clr in the same cycle as a valid step: pos=0 (clear wins); step and dir still reflect the transition.
REQ-026 err_clr=1 clears err; an illegal transition in the same cycle as err_clr wins, so err=1.
REQ-027 Latency without filter: an input edge reaches step, pos and zero exactly 3 clk edges later (2 synchronizer + 1 decode).
REQ-028 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-029 rst=1 SHALL immediately force: pos=0, step=0, dir=0, zero=0, err=0, FSM=INIT, synchronizers and filters cleared to 0.
REQ-030 A reset asserted mid-operation SHALL discard any in-flight transition.
REQ-031 After reset release, the first decode cycle SHALL be INIT, so no spurious step is produced regardless of the A/B levels.

Configuration
REQ-032 Macro QDEC_FILTER_EN controls the glitch filter.
- Defined: each synchronized channel (A, B, Z) SHALL pass through a filter that updates its output only after the input differs from the output for FILT_LEN consecutive cycles. The per-channel counter resets when the input matches the output. Latency becomes 3+FILT_LEN cycles.
- Undefined: the filters are absent and the synchronizer outputs feed the FSM directly, giving a latency of 3.

Verification
REQ-033 Reset with A=1, B=1, then release and hold for 10 cycles -> step never pulses; pos=0; err=0.
REQ-034 Four forward quadrature cycles (16 edges), each edge spaced 8 clk -> 16 step pulses; dir=0; pos=16; each pulse arrives at the required latency after its edge.
REQ-035 From pos=0, one reverse edge (00->10) -> pos=0xFFFF, dir=1. Then one forward edge -> pos=0x0000.
REQ-036 A and B toggled simultaneously from 00 to 11 -> err=1 with no step. err_clr pulse -> err=0. Illegal edge together with err_clr -> err stays 1.
REQ-037 At pos=5, enc_z rises in the same cycle as a forward step -> zero pulses once, step=1, pos=0. clr held 3 cycles -> zero high 3 cycles, pos=0.
REQ-038 With QDEC_FILTER_EN and FILT_LEN=3, a 2-cycle glitch on A -> no step. A 3-cycle-stable edge -> step 6 cycles after the edge.

Source files
------------

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: synchronizes A/B/Z, decodes gray-code steps into a position count,
// flags illegal double transitions. Define QDEC_FILTER_EN to add a per-channel glitch filter.
module quad_decoder #(
  parameter int WIDTH    = 16,
  parameter int FILT_LEN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             enc_z,
  input  logic             clr,
  input  logic             err_clr,
  output logic             step,
  output logic             dir,
  output logic             zero,
  output logic [WIDTH-1:0] pos,
  output logic             err
);

  typedef enum logic {
    INIT,
    TRACK
  } state_t;

  // Channel bit order everywhere: [2] = Z, [1] = A, [0] = B.
  logic [2:0] raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] chan;

  assign raw = {enc_z, enc_a, enc_b};

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef QDEC_FILTER_EN
  localparam logic [3:0] FILT_MAX = 4'(FILT_LEN - 1);
  localparam int         WARM     = 2 + FILT_LEN;

  logic [3:0] filt_cnt [3];
  logic [2:0] filt;

  // A channel output follows its input only after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt <= '0;
      for (int i = 0; i < 3; i++) filt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == filt[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == FILT_MAX) begin
          filt[i]     <= sync2[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + 4'd1;
        end
      end
    end
  end

  assign chan = filt;
`else
  localparam int WARM = 2;

  assign chan = sync2;
`endif

  // The pipeline restarts from zeros after reset; INIT waits until the sampled levels are real
  // so that the first AB capture cannot look like a transition.
  logic [4:0] warm_cnt;
  logic       warm_done;

  assign warm_done = (warm_cnt == 5'(WARM));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             warm_cnt <= '0;
    else if (!warm_done) warm_cnt <= warm_cnt + 5'd1;
  end

  state_t     state;
  state_t     state_next;
  logic [1:0] ab;
  logic [1:0] prev_ab;
  logic [1:0] prev_next;
  logic       z_prev;
  logic       z_rise;
  logic       up;
  logic       step_next;
  logic       dir_next;
  logic       zero_next;
  logic       err_next;
  logic [WIDTH-1:0] pos_next;

  assign ab     = chan[1:0];
  assign z_rise = warm_done & chan[2] & ~z_prev;
  // Forward order is 00->01->11->10: old A xor new B is 1 exactly for those steps.
  assign up     = prev_ab[1] ^ ab[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= INIT;
      prev_ab <= '0;
      z_prev  <= 1'b0;
      step    <= 1'b0;
      dir     <= 1'b0;
      zero    <= 1'b0;
      err     <= 1'b0;
      pos     <= '0;
    end else begin
      state   <= state_next;
      prev_ab <= prev_next;
      z_prev  <= chan[2];
      step    <= step_next;
      dir     <= dir_next;
      zero    <= zero_next;
      err     <= err_next;
      pos     <= pos_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    prev_next  = prev_ab;
    step_next  = 1'b0;
    dir_next   = dir;
    zero_next  = 1'b0;
    err_next   = err;
    pos_next   = pos;

    if (err_clr) err_next = 1'b0;

    case (state)
      INIT: begin
        prev_next = ab;
        if (warm_done) state_next = TRACK;
      end
      TRACK: begin
        prev_next = ab;
        if (ab == ~prev_ab) begin
          err_next = 1'b1;
        end else if (ab != prev_ab) begin
          step_next = 1'b1;
          dir_next  = ~up;
          pos_next  = up ? pos + WIDTH'(1) : pos - WIDTH'(1);
        end
      end
      default: state_next = INIT;
    endcase

    // Clear and index override only the count; step/dir still report the transition.
    if (clr || z_rise) begin
      zero_next = 1'b1;
      pos_next  = '0;
    end
  end

endmodule
